// File: rtl/mem_dump_streamer_if.sv
// Bundle of control, RAM read port and byte-stream signals for the memory dump streamer.
// The master side is the streamer. The slave side is the RAM/requester/sink environment.
interface mem_dump_streamer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  start, base_addr, length, mem_rdata, out_ready,
    output busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, length, mem_rdata, out_ready,
    input  busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mem_dump_streamer.sv
// Dumps a range of RAM words as a little-endian byte stream. The first byte is valid 2 cycles after start.
// Each word costs 2 overhead cycles. A byte holds while out_ready is low, with no timeout.
module mem_dump_streamer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_dump_streamer_if.master   bus
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES - 1);
  localparam logic [ADDR_W:0]   ONE_WORD = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND,
    FIN
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [ADDR_W:0]     words_left_q;
  logic [BIDX_W-1:0]   byte_idx_q;
  logic [DATA_W-1:0]   shift_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_en_q;
  logic                out_valid_q;
  logic [7:0]          out_data_q;
  logic                out_last_q;

  logic                hs;
  logic                last_word;

  assign hs        = out_valid_q && bus.out_ready;
  assign last_word = (words_left_q == ONE_WORD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (bus.length != '0) begin
              state_q      <= ISSUE;
              cur_addr_q   <= bus.base_addr;
              words_left_q <= bus.length;
              rd_en_q      <= 1'b1;
              busy_q       <= 1'b1;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end

        ISSUE: begin
          rd_en_q <= 1'b0;
          state_q <= CAPTURE;
        end

        // RAM data is valid this cycle. Byte 0 is presented directly, and the rest wait in the shifter.
        CAPTURE: begin
          shift_q     <= bus.mem_rdata >> 8;
          out_data_q  <= bus.mem_rdata[7:0];
          byte_idx_q  <= '0;
          out_valid_q <= 1'b1;
          out_last_q  <= last_word && (BYTES == 1);
          state_q     <= SEND;
        end

        SEND: begin
          if (hs) begin
            if (byte_idx_q == LAST_IDX) begin
              words_left_q <= words_left_q - ONE_WORD;
              cur_addr_q   <= cur_addr_q + 1'b1;
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              if (last_word) begin
                state_q <= FIN;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ISSUE;
                rd_en_q <= 1'b1;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              out_data_q <= shift_q[7:0];
              shift_q    <= shift_q >> 8;
              out_last_q <= last_word && ((byte_idx_q + 1'b1) == LAST_IDX);
            end
          end
        end

        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // cur_addr_q doubles as the RAM address. It only changes at word boundaries, so it holds outside ISSUE.
  assign bus.mem_addr  = cur_addr_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer with a synchronous-read RAM model and a byte sink.
module tb_mem_dump_streamer;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_dump_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_dump_streamer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;
  always @(posedge clk) if (bus.mem_rd_en) rdata_q <= ram[bus.mem_addr];
  assign bus.mem_rdata = rdata_q;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [127:0] got_pack;
  logic [15:0]  last_mask;
  logic [63:0]  rd_pack;
  int nbytes, rd_cnt, first_vld_k, done_k, done_cnt, valid_cnt, unstable, act;
  logic busy_at_done, busy_before_done;

  // k counts samples taken 1 time unit after each edge. k=0 is just after the edge that samples start.
  task automatic dump(input logic [AW-1:0] base, input logic [AW:0] len,
                      input int mode, input int poke_k);
    logic [7:0] prev_dat;
    logic       prev_stall;
    got_pack = '0; last_mask = '0; rd_pack = '0;
    nbytes = 0; rd_cnt = 0; first_vld_k = -1; done_k = -1; done_cnt = 0;
    valid_cnt = 0; unstable = 0; busy_at_done = 1'bx; busy_before_done = 1'b0;
    prev_stall = 1'b0; prev_dat = '0;
    bus.start = 1'b1; bus.base_addr = base; bus.length = len;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      bus.out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      if (k == poke_k) begin
        bus.start = 1'b1; bus.base_addr = 10'd100; bus.length = 11'd7;
      end else if (k == poke_k + 1) begin
        bus.start = 1'b0;
      end
      if (bus.mem_rd_en) begin
        rd_pack |= 64'(bus.mem_addr) << (10 * rd_cnt);
        rd_cnt++;
      end
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_dat)) unstable++;
      if (bus.out_valid) begin
        valid_cnt++;
        if (first_vld_k < 0) first_vld_k = k;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_pack |= 128'(bus.out_data) << (8 * nbytes);
        if (bus.out_last) last_mask |= 16'(1) << nbytes;
        nbytes++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_dat   = bus.out_data;
      if (bus.done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          busy_at_done = bus.busy;
        end
      end
      if (done_k < 0) busy_before_done = bus.busy;
      if (done_k >= 0 && k >= done_k + 4) break;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic idle_watch(input int cycles);
    act = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus.mem_rd_en || bus.out_valid || bus.busy || bus.done || bus.out_last) act++;
    end
  endtask

  initial begin
    ram[5]    = 32'hA1B2C3D4;
    ram[6]    = 32'h55667788;
    ram[1022] = 32'h11111111;
    ram[1023] = 32'h22222222;
    ram[0]    = 32'h33333333;
    ram[200]  = 32'h0A0B0C0D;
    ram[201]  = 32'hDDCCBBAA;
    ram[202]  = 32'h12345678;
    ram[203]  = 32'h9ABCDEF0;
    ram[300]  = 32'hCAFEBABE;

    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      128'(bus.busy),      128'(0));
    check("rst_done",      128'(bus.done),      128'(0));
    check("rst_rd_en",     128'(bus.mem_rd_en), 128'(0));
    check("rst_addr",      128'(bus.mem_addr),  128'(0));
    check("rst_valid",     128'(bus.out_valid), 128'(0));
    check("rst_data",      128'(bus.out_data),  128'(0));
    check("rst_last",      128'(bus.out_last),  128'(0));
    reset = 1'b0;
    idle_watch(20);
    check("idle_activity", 128'(act), 128'(0));

    // Single word at address 5
    dump(10'd5, 11'd1, 0, -1);
    check("w1_bytes",      got_pack,                  128'hA1B2C3D4);
    check("w1_nbytes",     128'(nbytes),              128'(4));
    check("w1_last",       128'(last_mask),           128'h8);
    check("w1_rd_cnt",     128'(rd_cnt),              128'(1));
    check("w1_rd_addr",    128'(rd_pack),             128'(5));
    check("w1_first_vld",  128'(first_vld_k),         128'(2));
    check("w1_done_k",     128'(done_k),              128'(6));
    check("w1_done_cnt",   128'(done_cnt),            128'(1));
    check("w1_busy_fin",   128'(busy_at_done),        128'(0));
    check("w1_busy_send",  128'(busy_before_done),    128'(1));

    // Same word with out_ready 1,0,0 repeating
    dump(10'd5, 11'd1, 1, -1);
    check("bp_bytes",      got_pack,                  128'hA1B2C3D4);
    check("bp_nbytes",     128'(nbytes),              128'(4));
    check("bp_stable",     128'(unstable),            128'(0));
    check("bp_last",       128'(last_mask),           128'h8);
    check("bp_done_k",     128'(done_k),              128'(13));

    // Three words wrapping past the top address
    dump(10'd1022, 11'd3, 0, -1);
    check("wr_bytes",      got_pack,                  128'h333333332222222211111111);
    check("wr_nbytes",     128'(nbytes),              128'(12));
    check("wr_last",       128'(last_mask),           128'h0800);
    check("wr_rd_cnt",     128'(rd_cnt),              128'(3));
    check("wr_rd_addrs",   128'(rd_pack),             128'h000FFFFE);
    check("wr_done_k",     128'(done_k),              128'(18));
    check("wr_busy_fin",   128'(busy_at_done),        128'(0));

    // length 0, with start raised again during FIN
    dump(10'd7, 11'd0, 0, 0);
    check("z_done_k",      128'(done_k),              128'(0));
    check("z_done_cnt",    128'(done_cnt),            128'(1));
    check("z_rd_cnt",      128'(rd_cnt),              128'(0));
    check("z_valid_cnt",   128'(valid_cnt),           128'(0));

    // Two words, with an ignored start mid-dump
    dump(10'd5, 11'd2, 0, 3);
    check("ig_bytes",      got_pack,                  128'h55667788A1B2C3D4);
    check("ig_nbytes",     128'(nbytes),              128'(8));
    check("ig_rd_addrs",   128'(rd_pack),             128'h1805);
    check("ig_last",       128'(last_mask),           128'h0080);
    check("ig_done_k",     128'(done_k),              128'(12));

    // Reset during SEND of word 2 of 4
    bus.out_ready = 1'b1;
    bus.start = 1'b1; bus.base_addr = 10'd200; bus.length = 11'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("mid_valid",     128'(bus.out_valid),       128'(1));
    check("mid_data",      128'(bus.out_data),        128'hBB);
    reset = 1'b1;
    #1;
    check("mid_rst_outs",  128'({bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr,
                                 bus.out_valid, bus.out_data, bus.out_last}), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    idle_watch(20);
    check("post_rst_idle", 128'(act),                 128'(0));
    dump(10'd300, 11'd1, 0, -1);
    check("pr_bytes",      got_pack,                  128'hCAFEBABE);
    check("pr_rd_addr",    128'(rd_pack),             128'h12C);
    check("pr_last",       128'(last_mask),           128'h8);
    check("pr_done_k",     128'(done_k),              128'(6));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_dump_streamer.md
Name: mem_dump_streamer

Overview:
- Reads a contiguous range of words from a synchronous-read RAM and serialises them onto a byte stream with a valid/ready handshake.
- It is the read-side counterpart of the RAM initial loader: the loader fills memory, and this block empties it out.
- Used to dump instruction/data memory contents to a debug UART or testbench monitor after a program run.

Parameters:
- ADDR_W, 10, word address width of the RAM read port.
- DATA_W, 32, RAM word width; must be a multiple of 8; BYTES = DATA_W/8.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address; latched on accepted start.
- length  input  ADDR_W+1  number of words to dump; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the dump completes.
- mem_rd_en  output  1  RAM read enable.
- mem_addr  output  ADDR_W  RAM word address.
- mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_rd_en.
- out_valid  output  1  byte available.
- out_data  output  8  current byte.
- out_last  output  1  marks the final byte of the whole dump; qualified by out_valid.
- out_ready  input  1  downstream accepts the byte when out_valid && out_ready.

Behaviour:
- Reset (asynchronous, at any time including mid-dump): state=IDLE and all outputs 0. This covers busy, done, mem_rd_en, mem_addr, out_valid, out_data and out_last. Internal counters and the shift register are also cleared. No byte is emitted after reset deasserts until a new start.
- States:
  - IDLE.
  - ISSUE: mem_rd_en=1, mem_addr=cur_addr, exactly one cycle.
  - CAPTURE: latch mem_rdata into the word register, byte_idx=0.
  - SEND.
  - FIN: done=1, one cycle.
- IDLE transitions:
  - start && length!=0 → ISSUE. Latch cur_addr=base_addr and words_left=length.
  - start && length==0 → FIN. No RAM read and no byte are produced.
- ISSUE → CAPTURE → SEND unconditionally.
- Latency: with start sampled at edge E0, mem_rd_en is high for the cycle E0–E1. The first out_valid is high from E2.
- SEND:
  - out_valid=1 and out_data=word[8*byte_idx +: 8], i.e. little-endian, byte 0 first.
  - out_data and out_valid hold stable while out_ready=0; there is no timeout.
  - On a handshake, byte_idx increments.
  - On a handshake with byte_idx==BYTES-1:
    - decrement words_left and increment cur_addr;
    - if words_left (before decrement) ==1 → FIN, else → ISSUE.
- Per-word cost: BYTES handshake cycles plus 2 overhead cycles (ISSUE, CAPTURE). out_valid is low during overhead cycles.
- out_last: high only in SEND with words_left==1 and byte_idx==BYTES-1.
- FIN → IDLE.
  - busy is high in ISSUE, CAPTURE and SEND, and low in FIN and IDLE.
  - done is high only in FIN.
- Address wrap: cur_addr increments modulo 2^ADDR_W. A range crossing the top address continues at 0.
- length up to 2^ADDR_W is legal; the full-memory dump uses length = 2^ADDR_W.
- start while not IDLE is ignored, and base_addr/length changes are ignored during a dump.
- start asserted in the same cycle as FIN is ignored. A new start is accepted only in IDLE.
- mem_addr holds its last value when mem_rd_en=0. It is don't-care outside ISSUE but must be deterministic (registered).

Test Plan:
- Reset then idle: no start → all outputs 0, mem_rd_en never asserted over 20 cycles.
- Single word, DATA_W=32:
  - Stimulus: RAM[5]=0xA1B2C3D4, base_addr=5, length=1, out_ready=1.
  - Response: mem_rd_en one cycle with mem_addr=5. Bytes D4,C3,B2,A1 on consecutive cycles, first valid 2 cycles after the start edge, out_last only on A1. done pulses once, the cycle after A1.
- Backpressure:
  - Stimulus: same word, out_ready toggling 1,0,0,1,...
  - Response: out_data stable across stalls, 4 handshakes total, byte order unchanged.
- Multi-word with wrap:
  - Stimulus: ADDR_W=10, base_addr=1022, length=3, RAM[1022]=0x11111111, RAM[1023]=0x22222222, RAM[0]=0x33333333.
  - Response: reads at 1022,1023,0; 12 bytes 11×4,22×4,33×4; out_last on byte 12; busy low after done.
- length=0 and ignored start:
  - length=0 → done pulse one cycle after start, no mem_rd_en, no out_valid.
  - start pulsed again during a 2-word dump → exactly 8 bytes are emitted.
- Reset mid-operation: assert reset during SEND of word 2 of 4 → outputs 0 immediately. After release there is no activity until a new start, which then dumps correctly from the new base_addr.
